// File: rtl/rect_pkg.sv
// Shared types and helpers for the rectangle compositor: the per-object record,
// the commit FSM state encoding and the edge clamp applied on shadow writes.
package rect_pkg;

  // Coordinate and colour widths of the stored object record.
  localparam int RECT_COORD_W = 10;
  localparam int RECT_COLOR_W = 3;

  // One screen-space rectangle with inclusive edges.
  typedef struct packed {
    logic                    en;
    logic [RECT_COORD_W-1:0] x0;
    logic [RECT_COORD_W-1:0] x1;
    logic [RECT_COORD_W-1:0] y0;
    logic [RECT_COORD_W-1:0] y1;
    logic [RECT_COLOR_W-1:0] color;
  } rect_t;

  // RUN accepts shadow writes; COMMIT is the single cycle that copies shadow to active.
  typedef enum logic {
    RUN    = 1'b0,
    COMMIT = 1'b1
  } state_t;

  // Pull a right/bottom edge that lies beyond the visible area back onto its last pixel.
  function automatic logic [RECT_COORD_W-1:0] clamp_coord(
    input logic [RECT_COORD_W-1:0] value,
    input logic [RECT_COORD_W-1:0] limit
  );
    return (value >= limit) ? (limit - 1'b1) : value;
  endfunction

endpackage

// File: rtl/rect_hit.sv
// Single-object coverage test: the pixel lies inside an enabled rectangle
// with inclusive edges. An inverted rectangle (x0>x1 or y0>y1) never hits.
module rect_hit #(
  parameter int COORD_W = 10
) (
  input  logic               en,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               hit
);

  assign hit = en && (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);

endmodule

// File: rtl/rect_compositor.sv
// Double-buffered, two-stage pipelined rectangle compositor.
// Game logic writes the shadow object set; the whole set is copied to the
// active set in one COMMIT cycle following a frame_start, so no frame tears.
// Stage 1 tests every active object against the pixel, stage 2 picks the
// lowest-index hit and registers the outputs (2 cycles CounterX/Y -> pix_*).
// Coordinate/colour widths of the stored records come from rect_pkg; keep
// COORD_W and COLOR_W equal to RECT_COORD_W and RECT_COLOR_W.
// Optional feature: define RECT_COMPOSITOR_COLLIDE_EN to add sticky
// object-0 collision outputs collide and collide_mask.
module rect_compositor
  import rect_pkg::*;
#(
  parameter int                  NUM_OBJ  = 4,
  parameter int                  COORD_W  = RECT_COORD_W,
  parameter int                  COLOR_W  = RECT_COLOR_W,
  parameter int                  H_MAX    = 640,
  parameter int                  V_MAX    = 480,
  parameter logic [COLOR_W-1:0]  BG_COLOR = '0,
  localparam int                 IDX_W    = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [COORD_W-1:0] CounterX,
  input  logic [COORD_W-1:0] CounterY,
  input  logic               inDisplayArea,
  input  logic               frame_start,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic               wr_en,
  input  logic [COORD_W-1:0] wr_x0,
  input  logic [COORD_W-1:0] wr_x1,
  input  logic [COORD_W-1:0] wr_y0,
  input  logic [COORD_W-1:0] wr_y1,
  input  logic [COLOR_W-1:0] wr_color,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_hit,
  output logic [IDX_W-1:0]   pix_obj,
  output logic               commit_pulse
`ifdef RECT_COMPOSITOR_COLLIDE_EN
  ,
  output logic               collide,
  output logic [NUM_OBJ-1:0] collide_mask
`endif
);

  // ---------------------------------------------------------------------------
  // Register banks and control state
  // ---------------------------------------------------------------------------
  rect_t              shadow [NUM_OBJ];
  rect_t              active [NUM_OBJ];
  logic               dirty;
  state_t             state;
  state_t             state_next;
  logic               out_of_reset;
  logic               wr_fire;
  logic               idx_valid;
  rect_t              wr_rect;

  // Pipeline registers
  logic [NUM_OBJ-1:0] hit_comb;
  logic [NUM_OBJ-1:0] hit_s1;
  logic               disp_s1;
  logic [COLOR_W-1:0] color_s1 [NUM_OBJ];

  // Priority encoder results
  logic               any_hit;
  logic [IDX_W-1:0]   win_idx;
  logic [COLOR_W-1:0] win_color;

  // Writes are refused while reset is held, until the first edge after release,
  // and during the COMMIT cycle.
  assign wr_ready     = out_of_reset && (state == RUN);
  assign wr_fire      = wr_valid && wr_ready;
  assign commit_pulse = (state == COMMIT);

  // Marks the first clock edge after reset release so wr_ready stays low in reset.
  // NOTE: state elements are written with non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) out_of_reset <= 1'b0;
    else          out_of_reset <= 1'b1;
  end

  // Commit FSM state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= RUN;
    else          state <= state_next;
  end

  // Next state: a frame_start with pending shadow edits takes one COMMIT cycle.
  // NOTE: every combinationally driven variable gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (frame_start && dirty) state_next = COMMIT;
      COMMIT:  state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Clamp the incoming record and check whether its index names a real object.
  always_comb begin
    wr_rect.en    = wr_en;
    wr_rect.x0    = wr_x0;
    wr_rect.x1    = clamp_coord(wr_x1, COORD_W'(H_MAX));
    wr_rect.y0    = wr_y0;
    wr_rect.y1    = clamp_coord(wr_y1, COORD_W'(V_MAX));
    wr_rect.color = wr_color;
    idx_valid     = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (wr_idx == IDX_W'(i)) idx_valid = 1'b1;
    end
  end

  // Shadow bank and dirty flag: accepted writes land here; indices beyond
  // NUM_OBJ match no entry and are dropped without marking the set dirty.
  // NOTE: the object banks are explicit flops that must power up disabled,
  // so they are reset like any control register rather than left as a RAM.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_OBJ; i++) shadow[i] <= '0;
      dirty <= 1'b0;
    end else begin
      if (state == COMMIT)             dirty <= 1'b0;
      else if (wr_fire && idx_valid)   dirty <= 1'b1;
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (wr_fire && (wr_idx == IDX_W'(i))) shadow[i] <= wr_rect;
      end
    end
  end

  // Active bank: changes only at the end of the COMMIT cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_OBJ; i++) active[i] <= '0;
    end else if (state == COMMIT) begin
      for (int i = 0; i < NUM_OBJ; i++) active[i] <= shadow[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: one comparator per object against the active set
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_hit
    rect_hit #(
      .COORD_W (COORD_W)
    ) u_rect_hit (
      .en  (active[g].en),
      .x0  (active[g].x0),
      .x1  (active[g].x1),
      .y0  (active[g].y0),
      .y1  (active[g].y1),
      .x   (CounterX),
      .y   (CounterY),
      .hit (hit_comb[g])
    );
  end

  // Stage-1 registers; colours travel with the hit vector so a commit between
  // the two stages cannot pair old geometry with new colours.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hit_s1  <= '0;
      disp_s1 <= 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) color_s1[i] <= '0;
    end else begin
      hit_s1  <= hit_comb;
      disp_s1 <= inDisplayArea;
      for (int i = 0; i < NUM_OBJ; i++) color_s1[i] <= active[i].color;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: fixed-priority encoder, lowest index wins
  // ---------------------------------------------------------------------------
  // Scan from the highest index down so the last assignment is the lowest hit.
  always_comb begin
    any_hit   = 1'b0;
    win_idx   = '0;
    win_color = BG_COLOR;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (hit_s1[i]) begin
        any_hit   = 1'b1;
        win_idx   = IDX_W'(i);
        win_color = color_s1[i];
      end
    end
  end

  // Output registers, forced to zero outside the display area.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_color <= '0;
      pix_hit   <= 1'b0;
      pix_obj   <= '0;
    end else if (disp_s1) begin
      pix_color <= win_color;
      pix_hit   <= any_hit;
      pix_obj   <= win_idx;
    end else begin
      pix_color <= '0;
      pix_hit   <= 1'b0;
      pix_obj   <= '0;
    end
  end

`ifdef RECT_COMPOSITOR_COLLIDE_EN
  // ---------------------------------------------------------------------------
  // Optional collision detector: object 0 against every other object
  // ---------------------------------------------------------------------------
  logic [NUM_OBJ-1:0] collide_set;

  // Objects that share a visible pixel with object 0 in stage 1.
  always_comb begin
    collide_set = '0;
    if (disp_s1 && hit_s1[0]) begin
      for (int k = 1; k < NUM_OBJ; k++) collide_set[k] = hit_s1[k];
    end
  end

  // Sticky flags cleared by every frame_start; a new hit on that same cycle survives.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      collide      <= 1'b0;
      collide_mask <= '0;
    end else begin
      collide      <= (frame_start ? 1'b0 : collide) | (|collide_set);
      collide_mask <= (frame_start ? '0 : collide_mask) | collide_set;
    end
  end
`endif

endmodule

// File: doc/rect_compositor.md
# rect_compositor

Parametrised, pipelined rectangle compositor that replaces the hard-wired bird/pipe draw logic in the VGA top. Holds NUM_OBJ screen-space rectangles, each with an enable and a colour, in double-buffered registers. Software/game FSMs write the shadow set through a valid/ready port, and the set is committed atomically at frame start. Per pixel, it outputs the colour of the highest-priority covering object, two cycles after CounterX/CounterY.

## Interface
- NUM_OBJ, 4, number of rectangle channels (1..16); index 0 has highest priority
- COORD_W, 10, width of all coordinates
- COLOR_W, 3, colour width ({r,g,b} for the 3-bit DAC)
- H_MAX, 640, visible width; right edges clamp to H_MAX-1
- V_MAX, 480, visible height; bottom edges clamp to V_MAX-1
- BG_COLOR, 0, colour output where no object covers the pixel
---
- Clk  in  1  pixel clock
- Reset_n  in  1  asynchronous, active-low reset
- CounterX  in  COORD_W  current pixel column from hvsync_generator
- CounterY  in  COORD_W  current pixel row
- inDisplayArea  in  1  visible-region qualifier
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- wr_valid  in  1  shadow write request
- wr_ready  out  1  shadow write accepted when valid&ready
- wr_idx  in  clog2(NUM_OBJ)  target object
- wr_en  in  1  object enable
- wr_x0, wr_x1, wr_y0, wr_y1  in  COORD_W each  inclusive left/right/top/bottom edges
- wr_color  in  COLOR_W  object colour
- pix_color  out  COLOR_W  composited colour, already gated by the delayed inDisplayArea
- pix_hit  out  1  some enabled object covers the pixel
- pix_obj  out  clog2(NUM_OBJ)  index of the winning object (0 when no hit)
- commit_pulse  out  1  one cycle; the shadow set was copied to the active set

## Operation
- FSM states: RUN, COMMIT.
- RUN: wr_ready=1. An accepted write updates shadow[wr_idx] and sets dirty.
  - Clamp on write: x1>=H_MAX becomes H_MAX-1; y1>=V_MAX becomes V_MAX-1.
  - An object with x0>x1 or y0>y1 after clamping is stored as-is and never hits.
  - wr_idx>=NUM_OBJ is accepted and discarded.
- RUN to COMMIT: frame_start & dirty. With frame_start & !dirty, the FSM stays in RUN and nothing happens.
- COMMIT, lasting exactly one cycle:
  - active <= shadow; dirty <= 0; commit_pulse=1; wr_ready=0.
  - A write held valid during COMMIT stalls one cycle and lands in the next frame's shadow.
- Hit test, stage 1: hit[i] = en[i] & x0<=X<=x1 & y0<=Y<=y1, using unsigned compares on the active set. Stage 1 also registers inDisplayArea.
- Stage 2: fixed-priority encoder, lowest index wins. Registers pix_color, pix_hit and pix_obj, gated by the stage-1 inDisplayArea. Outside the display area, all three outputs are 0.
- Reset, including mid-frame or mid-write:
  - all shadow/active entries 0 (disabled); dirty=0; FSM RUN.
  - pix_color=0, pix_hit=0, pix_obj=0, commit_pulse=0, wr_ready=0 while Reset_n is low.
  - wr_ready=1 from the first edge after release.

## Timing
- Latency CounterX/Y to pix_*: 2 Clk cycles, fully pipelined, one pixel per cycle, no bubbles.
- The active set changes only in the COMMIT cycle. Pixels sampled before the edge use the old set; pixels after use the new set. There is no mid-frame tearing.
- Write acceptance: 1 per cycle in RUN; 0 in COMMIT.
- commit_pulse occurs 1 cycle after the frame_start that triggers it.

## Configuration
- RECT_COMPOSITOR_COLLIDE_EN defined:
  - Adds outputs collide (1 bit) and collide_mask (NUM_OBJ bits).
  - Any pixel where hit[0] and hit[k] (k>0) are both set during inDisplayArea sets collide_mask[k] and collide (sticky).
  - Values are taken from stage 1 and registered in stage 2.
  - Both are cleared on every frame_start (commit or not) and on reset. A set on the same cycle as frame_start wins.
- Undefined: no collision logic and no extra ports; area is compare plus encoder only.

## Structure
- Package rect_pkg:
  - rect_t struct {en, x0, x1, y0, y1, color}
  - FSM state enum {RUN, COMMIT}
  - clamp helper function
- Sub-module rect_hit: a single-object comparator, instantiated NUM_OBJ times by generate.
- The top-level holds the register banks, the FSM and the priority encoder.

## Test plan
- Reset with defaults; write obj0 = {en=1, 100..119, 200..219, color=3'b100}; pulse frame_start.
  - commit_pulse 1 cycle later.
  - Pixel (110,210) gives pix_color=100, pix_obj=0 two cycles later.
  - Pixel (120,210) gives BG_COLOR.
- Overlap: obj0 red at 0..50, obj2 green at 40..90, both spanning y=10.
  - Pixel (45,10) gives red, pix_obj=0.
  - Pixel (60,10) gives green, pix_obj=2.
- Clamp: write x1=700, y1=500.
  - Pixel (639,479) hits.
  - Write x0=30, x1=20: no pixel ever hits.
- Double buffer: write a new obj0 position mid-frame without frame_start.
  - The old position is still drawn.
  - After frame_start and commit, the new position is drawn.
  - frame_start with no write gives no commit_pulse.
- Hold wr_valid across a frame_start (dirty=1): wr_ready drops for exactly 1 cycle, and the write is applied in the following frame.
- With COLLIDE_EN: obj0 overlapping obj1 during one frame sets collide=1, collide_mask=0b0010. Both clear on the next frame_start. Asserting Reset_n low mid-scan zeroes all outputs immediately.
